// File: rtl/stage4ma.sv
// ============================================================================
// Module      : stage4ma
// Description : Memory-access pipeline stage. Non-memory ops pass through in
//               one cycle; loads/stores run a req/ack bus access with timeout.
// Revision    : 1.0
// ============================================================================
`default_nettype none

`ifndef OPC_R_LD
`define OPC_R_LD  8'h20
`endif
`ifndef OPC_I_LDi
`define OPC_I_LDi 8'h21
`endif
`ifndef OPC_R_ST
`define OPC_R_ST  8'h22
`endif
`ifndef OPC_I_STi
`define OPC_I_STi 8'h23
`endif

module stage4ma #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable_in,
    input  logic [23:0] pc_in,
    input  logic [23:0] instr_in,
    input  logic [3:0]  tgt_gp_in,
    input  logic [3:0]  tgt_sr_in,
    input  logic [23:0] result_in,
    input  logic [3:0]  flags_in,
    input  logic [23:0] store_data_in,
    input  logic        branch_taken_in,
    output logic        stall_out,
    output logic        mem_req_out,
    output logic        mem_we_out,
    output logic [23:0] mem_addr_out,
    output logic [23:0] mem_wdata_out,
    input  logic        mem_ack_in,
    input  logic [23:0] mem_rdata_in,
    output logic        enable_out,
    output logic [23:0] pc_out,
    output logic [23:0] instr_out,
    output logic [3:0]  tgt_gp_out,
    output logic [3:0]  tgt_sr_out,
    output logic [23:0] result_out,
    output logic [3:0]  flags_out,
    output logic        branch_taken_out,
    output logic        mem_err_out
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;

    logic [23:0] hold_pc, hold_pc_nxt;
    logic [23:0] hold_instr, hold_instr_nxt;
    logic [3:0]  hold_gp, hold_gp_nxt;
    logic [3:0]  hold_sr, hold_sr_nxt;
    logic [3:0]  hold_flags, hold_flags_nxt;
    logic        hold_bt, hold_bt_nxt;

    logic        req_nxt, we_nxt, enable_nxt, err_nxt, bt_nxt;
    logic [23:0] addr_nxt, wdata_nxt, pc_nxt, instr_nxt, result_nxt;
    logic [3:0]  gp_nxt, sr_nxt, flags_nxt;

    logic [7:0]  opcode;
    logic        is_rd, is_wr;

    assign opcode    = instr_in[23:16];
    assign is_rd     = (opcode == `OPC_R_LD) || (opcode == `OPC_I_LDi);
    assign is_wr     = (opcode == `OPC_R_ST) || (opcode == `OPC_I_STi);
    assign stall_out = (state == BUSY);

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        hold_pc_nxt    = hold_pc;
        hold_instr_nxt = hold_instr;
        hold_gp_nxt    = hold_gp;
        hold_sr_nxt    = hold_sr;
        hold_flags_nxt = hold_flags;
        hold_bt_nxt    = hold_bt;
        req_nxt        = mem_req_out;
        we_nxt         = mem_we_out;
        addr_nxt       = mem_addr_out;
        wdata_nxt      = mem_wdata_out;
        enable_nxt     = 1'b0;
        pc_nxt         = pc_out;
        instr_nxt      = instr_out;
        gp_nxt         = tgt_gp_out;
        sr_nxt         = tgt_sr_out;
        result_nxt     = result_out;
        flags_nxt      = flags_out;
        bt_nxt         = branch_taken_out;
        err_nxt        = mem_err_out;

        case (state)
            IDLE: begin
                if (enable_in) begin
                    if (is_rd || is_wr) begin
                        hold_pc_nxt    = pc_in;
                        hold_instr_nxt = instr_in;
                        hold_gp_nxt    = tgt_gp_in;
                        hold_sr_nxt    = tgt_sr_in;
                        hold_flags_nxt = flags_in;
                        hold_bt_nxt    = branch_taken_in;
                        addr_nxt       = result_in;
                        we_nxt         = is_wr;
                        wdata_nxt      = is_wr ? store_data_in : 24'd0;
                        req_nxt        = 1'b1;
                        cnt_nxt        = '0;
                        state_nxt      = BUSY;
                    end else begin
                        pc_nxt     = pc_in;
                        instr_nxt  = instr_in;
                        gp_nxt     = tgt_gp_in;
                        sr_nxt     = tgt_sr_in;
                        flags_nxt  = flags_in;
                        bt_nxt     = branch_taken_in;
                        result_nxt = result_in;
                        err_nxt    = 1'b0;
                        enable_nxt = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (mem_ack_in || cnt == C_LAST) begin
                    // Ack takes priority over an expiring timeout.
                    req_nxt    = 1'b0;
                    state_nxt  = IDLE;
                    enable_nxt = 1'b1;
                    pc_nxt     = hold_pc;
                    instr_nxt  = hold_instr;
                    gp_nxt     = hold_gp;
                    sr_nxt     = hold_sr;
                    flags_nxt  = hold_flags;
                    bt_nxt     = hold_bt;
                    if (mem_ack_in) begin
                        err_nxt    = 1'b0;
                        result_nxt = mem_we_out ? mem_addr_out : mem_rdata_in;
                    end else begin
                        err_nxt    = 1'b1;
                        result_nxt = 24'd0;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            hold_pc          <= '0;
            hold_instr       <= '0;
            hold_gp          <= '0;
            hold_sr          <= '0;
            hold_flags       <= '0;
            hold_bt          <= 1'b0;
            mem_req_out      <= 1'b0;
            mem_we_out       <= 1'b0;
            mem_addr_out     <= '0;
            mem_wdata_out    <= '0;
            enable_out       <= 1'b0;
            pc_out           <= '0;
            instr_out        <= '0;
            tgt_gp_out       <= '0;
            tgt_sr_out       <= '0;
            result_out       <= '0;
            flags_out        <= '0;
            branch_taken_out <= 1'b0;
            mem_err_out      <= 1'b0;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            hold_pc          <= hold_pc_nxt;
            hold_instr       <= hold_instr_nxt;
            hold_gp          <= hold_gp_nxt;
            hold_sr          <= hold_sr_nxt;
            hold_flags       <= hold_flags_nxt;
            hold_bt          <= hold_bt_nxt;
            mem_req_out      <= req_nxt;
            mem_we_out       <= we_nxt;
            mem_addr_out     <= addr_nxt;
            mem_wdata_out    <= wdata_nxt;
            enable_out       <= enable_nxt;
            pc_out           <= pc_nxt;
            instr_out        <= instr_nxt;
            tgt_gp_out       <= gp_nxt;
            tgt_sr_out       <= sr_nxt;
            result_out       <= result_nxt;
            flags_out        <= flags_nxt;
            branch_taken_out <= bt_nxt;
            mem_err_out      <= err_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_stage4ma.sv
// ============================================================================
// Module      : tb_stage4ma
// Description : Scoreboard bench for stage4ma with TIMEOUT = 4.
// Revision    : 1.0
// ============================================================================
`default_nettype none

`ifndef OPC_R_LD
`define OPC_R_LD  8'h20
`endif
`ifndef OPC_I_LDi
`define OPC_I_LDi 8'h21
`endif
`ifndef OPC_R_ST
`define OPC_R_ST  8'h22
`endif
`ifndef OPC_I_STi
`define OPC_I_STi 8'h23
`endif

module tb_stage4ma;

    localparam logic [7:0] C_MOV = 8'h01;
    localparam logic [7:0] C_ADD = 8'h02;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable_in = 1'b0;
    logic [23:0] pc_in = '0, instr_in = '0, result_in = '0, store_data_in = '0;
    logic [3:0]  tgt_gp_in = '0, tgt_sr_in = '0, flags_in = '0;
    logic        branch_taken_in = 1'b0;
    logic        stall_out, mem_req_out, mem_we_out;
    logic [23:0] mem_addr_out, mem_wdata_out;
    logic        mem_ack_in = 1'b0;
    logic [23:0] mem_rdata_in = '0;
    logic        enable_out;
    logic [23:0] pc_out, instr_out, result_out;
    logic [3:0]  tgt_gp_out, tgt_sr_out, flags_out;
    logic        branch_taken_out, mem_err_out;

    stage4ma #(.TIMEOUT(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .enable_in(enable_in), .pc_in(pc_in),
        .instr_in(instr_in), .tgt_gp_in(tgt_gp_in), .tgt_sr_in(tgt_sr_in),
        .result_in(result_in), .flags_in(flags_in), .store_data_in(store_data_in),
        .branch_taken_in(branch_taken_in), .stall_out(stall_out),
        .mem_req_out(mem_req_out), .mem_we_out(mem_we_out),
        .mem_addr_out(mem_addr_out), .mem_wdata_out(mem_wdata_out),
        .mem_ack_in(mem_ack_in), .mem_rdata_in(mem_rdata_in),
        .enable_out(enable_out), .pc_out(pc_out), .instr_out(instr_out),
        .tgt_gp_out(tgt_gp_out), .tgt_sr_out(tgt_sr_out), .result_out(result_out),
        .flags_out(flags_out), .branch_taken_out(branch_taken_out),
        .mem_err_out(mem_err_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] pc;
        logic [23:0] instr;
        logic [23:0] result;
        logic [3:0]  flags;
        logic [3:0]  gp;
        logic [3:0]  sr;
        logic        bt;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    // Monitor: every enable_out pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && enable_out === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_enable_out", 24'(enable_out), 24'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("instr_out",  instr_out, e.instr);
                check("pc_out",     pc_out, e.pc);
                check("result_out", result_out, e.result);
                check("flags_out",  24'(flags_out), 24'(e.flags));
                check("tgt_gp_out", 24'(tgt_gp_out), 24'(e.gp));
                check("tgt_sr_out", 24'(tgt_sr_out), 24'(e.sr));
                check("branch_taken_out", 24'(branch_taken_out), 24'(e.bt));
                check("mem_err_out", 24'(mem_err_out), 24'(e.err));
            end
        end
    end

    // Presents an instruction and pushes its expected write-back record.
    task automatic present(input logic [7:0] opc, input logic [23:0] pc,
                           input logic [23:0] res, input logic [23:0] sd,
                           input logic [3:0] fl, input logic [3:0] gp,
                           input logic [3:0] sr, input logic bt,
                           input logic [23:0] exp_res, input logic exp_err,
                           input logic push);
        exp_t e;
        pc_in = pc; instr_in = {opc, 16'h1234 ^ pc[15:0]}; result_in = res;
        store_data_in = sd; flags_in = fl; tgt_gp_in = gp; tgt_sr_in = sr;
        branch_taken_in = bt; enable_in = 1'b1;
        e = '{pc: pc, instr: {opc, 16'h1234 ^ pc[15:0]}, result: exp_res,
              flags: fl, gp: gp, sr: sr, bt: bt, err: exp_err};
        if (push) sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_enable_out", 24'(enable_out), 24'd0);
        check("rst_stall_out",  24'(stall_out), 24'd0);
        check("rst_mem_req",    24'(mem_req_out), 24'd0);
        check("rst_result_out", result_out, 24'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Pass-through MOV
        present(C_MOV, 24'h000010, 24'h00ABCD, 24'h0, 4'h2, 4'h3, 4'h5, 1'b1,
                24'h00ABCD, 1'b0, 1'b1);
        tick();
        enable_in = 1'b0;
        check("mov_no_req", 24'(mem_req_out), 24'd0);
        check("mov_no_stall", 24'(stall_out), 24'd0);

        // Ack while IDLE is ignored
        mem_ack_in = 1'b1; mem_rdata_in = 24'hDEAD00;
        tick(); tick();
        mem_ack_in = 1'b0;

        // LDi, 3 wait cycles, ack on the 4th BUSY edge (also the timeout edge)
        present(`OPC_I_LDi, 24'h000020, 24'h000100, 24'h0, 4'h1, 4'h7, 4'h0, 1'b0,
                24'h123456, 1'b0, 1'b1);
        tick();
        enable_in = 1'b0;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            if (mem_req_out && stall_out && !mem_we_out && mem_addr_out == 24'h000100) n++;
            tick();
        end
        check("ld_req_before_ack", 24'(n), 24'd3);
        check("ld_req_4th", 24'(mem_req_out), 24'd1);
        mem_ack_in = 1'b1; mem_rdata_in = 24'h123456;
        tick();
        mem_ack_in = 1'b0;
        check("ld_req_drop", 24'(mem_req_out), 24'd0);
        check("ld_stall_drop", 24'(stall_out), 24'd0);
        tick();

        // Zero-wait ST
        present(`OPC_R_ST, 24'h000030, 24'h000200, 24'hCAFE01, 4'h8, 4'h0, 4'h2, 1'b0,
                24'h000200, 1'b0, 1'b1);
        tick();
        enable_in = 1'b0;
        check("st_we", 24'(mem_we_out), 24'd1);
        check("st_wdata", mem_wdata_out, 24'hCAFE01);
        check("st_addr", mem_addr_out, 24'h000200);
        mem_ack_in = 1'b1; mem_rdata_in = 24'h555555;
        tick();
        mem_ack_in = 1'b0;
        tick();

        // Timeout: LD with no ack
        present(`OPC_R_LD, 24'h000040, 24'h000300, 24'h0, 4'hF, 4'h9, 4'hA, 1'b1,
                24'h000000, 1'b1, 1'b1);
        tick();
        enable_in = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem_req_out) begin n++; tick(); end
        end
        check("timeout_req_cycles", 24'(n), 24'd4);
        check("timeout_stall_idle", 24'(stall_out), 24'd0);
        tick();

        // Back-to-back: LD then ADD held upstream by the stall
        present(`OPC_R_LD, 24'h000050, 24'h000400, 24'h0, 4'h4, 4'h1, 4'h1, 1'b0,
                24'h0F0F0F, 1'b0, 1'b1);
        tick();
        present(C_ADD, 24'h000054, 24'h000777, 24'h0, 4'h6, 4'hC, 4'hD, 1'b0,
                24'h000777, 1'b0, 1'b1);
        check("b2b_stall", 24'(stall_out), 24'd1);
        mem_ack_in = 1'b1; mem_rdata_in = 24'h0F0F0F;
        tick();
        mem_ack_in = 1'b0;
        check("b2b_ld_done", instr_out, {`OPC_R_LD, 16'h1234 ^ 16'h0050});
        tick();
        enable_in = 1'b0;
        check("b2b_add_enable", 24'(enable_out), 24'd1);
        check("b2b_add_instr", instr_out, {C_ADD, 16'h1234 ^ 16'h0054});
        tick();
        check("b2b_single_pulse", 24'(enable_out), 24'd0);

        // Reset mid-transaction
        present(`OPC_I_STi, 24'h000060, 24'h000500, 24'h111111, 4'h0, 4'h0, 4'h0, 1'b0,
                24'h0, 1'b0, 1'b0);
        tick();
        enable_in = 1'b0;
        check("rmid_req_before", 24'(mem_req_out), 24'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rmid_req", 24'(mem_req_out), 24'd0);
        check("rmid_stall", 24'(stall_out), 24'd0);
        check("rmid_enable", 24'(enable_out), 24'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        present(`OPC_I_STi, 24'h000070, 24'h000600, 24'h222222, 4'h3, 4'h2, 4'h1, 1'b1,
                24'h000600, 1'b0, 1'b1);
        tick();
        enable_in = 1'b0;
        check("post_rst_wdata", mem_wdata_out, 24'h222222);
        mem_ack_in = 1'b1;
        tick();
        mem_ack_in = 1'b0;
        tick(); tick();

        check("scoreboard_drained", 24'(sb.size()), 24'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
